// File: rtl/debounce_pkg.sv
// Shared types and helpers for the switch debouncer: per-bit FSM state
// encoding and the stability-counter width calculation.
package debounce_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    PEND   = 1'b1
  } db_state_t;

  localparam int DEFAULT_WIDTH        = 4;
  localparam int DEFAULT_STABLE_TICKS = 4;

  // Counter must hold 0..ticks-1; keep at least one bit so the
  // declaration stays legal even for an illegal parameter value.
  function automatic int db_cnt_width(input int ticks);
    int w;
    w = (ticks > 1) ? $clog2(ticks) : 1;
    return w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced input: two-flop synchronizer, STABLE/PEND stability FSM
// with a tick-gated counter, and registered rise/fall pulses.
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic      clk,
  input  logic      nrst,
  input  logic      tick,
  input  logic      raw,
  output logic      q,
  output logic      rise,
  output logic      fall,
  output logic      accept,
  output db_state_t state
);

  localparam int              CW       = db_cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

  generate
    if (STABLE_TICKS < 2) begin : g_bad_ticks
      $error("debounce_bit: STABLE_TICKS must be at least 2");
    end
  endgenerate

  logic          s1;
  logic          s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  db_state_t     state_d;
  logic          q_d;
  logic          rise_d;
  logic          fall_d;

  // Synchronizer: only s is allowed to reach the FSM.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= raw;
      s  <= s1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= STABLE;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      q     <= q_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

  // Abort (s back to q) is tested before the tick so it always wins.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    q_d     = q;
    accept  = 1'b0;
    case (state)
      STABLE: begin
        if (s != q) begin
          state_d = PEND;
          cnt_d   = '0;
        end
      end
      PEND: begin
        if (s == q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (tick && (cnt == CNT_LAST)) begin
          accept  = 1'b1;
          q_d     = s;
          cnt_d   = '0;
          state_d = STABLE;
        end else if (tick) begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
    rise_d = accept & s;
    fall_d = accept & ~s;
  end

endmodule

// File: rtl/sw_debounce.sv
// Debounces a bus of switch inputs; each bit is an independent
// debounce_bit, and changed flags any accepted edge in the same cycle.
module sw_debounce
  import debounce_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             tick,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic [WIDTH-1:0] dbg_pend
);

  logic [WIDTH-1:0] accept;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      db_state_t bit_state;

      debounce_bit #(
        .STABLE_TICKS(STABLE_TICKS)
      ) u_bit (
        .clk   (clk),
        .nrst  (nrst),
        .tick  (tick),
        .raw   (raw[i]),
        .q     (q[i]),
        .rise  (rise[i]),
        .fall  (fall[i]),
        .accept(accept[i]),
        .state (bit_state)
      );

      assign dbg_pend[i] = (bit_state == PEND);
    end
  endgenerate

  // Registered from the pre-register accept so it lines up with rise/fall.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      changed <= 1'b0;
    end else begin
      changed <= |accept;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce (WIDTH=4, STABLE_TICKS=4) with
// hand-computed edge-by-edge expectations.
module tb_sw_debounce;

  logic       clk;
  logic       nrst;
  logic       tick;
  logic [3:0] raw;
  logic [3:0] q;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       changed;
  logic [3:0] dbg_pend;

  int n_cmp;
  int n_err;

  logic [3:0] acc_rise;
  logic [3:0] acc_fall;
  int         chg_cnt;

  sw_debounce #(
    .WIDTH(4),
    .STABLE_TICKS(4)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .tick    (tick),
    .raw     (raw),
    .q       (q),
    .rise    (rise),
    .fall    (fall),
    .changed (changed),
    .dbg_pend(dbg_pend)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n active edges, sampling 1 time unit after each edge.
  task automatic run_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      acc_rise |= rise;
      acc_fall |= fall;
      if (changed) chg_cnt++;
    end
  endtask

  task automatic clear_watch();
    acc_rise = '0;
    acc_fall = '0;
    chg_cnt  = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_watch();
    nrst = 1'b0;
    tick = 1'b1;
    raw  = 4'hF;

    // Reset held with all inputs high: everything stays 0.
    run_edges(3);
    check("rst_q", q, 4'h0);
    check("rst_rise", rise, 4'h0);
    check("rst_fall", fall, 4'h0);
    check("rst_changed", changed, 1'b0);

    // Release: first edge after release is edge 0, acceptance at edge 6.
    nrst = 1'b1;
    clear_watch();
    run_edges(6);
    check("rel_q_early", q, 4'h0);
    check("rel_rise_early", acc_rise, 4'h0);
    run_edges(1);
    check("rel_q", q, 4'hF);
    check("rel_rise", rise, 4'hF);
    check("rel_changed", changed, 1'b1);
    run_edges(1);
    check("rel_rise_off", rise, 4'h0);
    check("rel_changed_off", changed, 1'b0);

    // All fall together.
    raw = 4'h0;
    run_edges(7);
    check("fall_all", fall, 4'hF);
    check("fall_all_q", q, 4'h0);
    run_edges(1);
    check("fall_all_off", fall, 4'h0);

    // Clean step on bit 0.
    raw = 4'h1;
    clear_watch();
    run_edges(6);
    check("step_q_early", q, 4'h0);
    check("step_rise_early", acc_rise, 4'h0);
    run_edges(1);
    check("step_q", q, 4'h1);
    check("step_rise", rise, 4'h1);
    check("step_changed", changed, 1'b1);
    run_edges(1);
    check("step_rise_off", rise, 4'h0);
    check("step_changed_off", changed, 1'b0);
    check("step_q_hold", q, 4'h1);

    // Bounce on bit 2: 1 x3, 0 x2, then steady 1 sampled from edge E0.
    clear_watch();
    raw = 4'h5;
    run_edges(3);
    raw = 4'h1;
    run_edges(2);
    raw = 4'h5;
    run_edges(6);
    check("bnc_no_pulse", acc_rise, 4'h0);
    check("bnc_q_early", q, 4'h1);
    run_edges(1);
    check("bnc_rise", rise, 4'h4);
    check("bnc_q", q, 4'h5);
    clear_watch();
    run_edges(8);
    check("bnc_single", acc_rise, 4'h0);

    // Prepare bit 1 high.
    raw = 4'h7;
    run_edges(9);
    check("gate_pre_q", q, 4'h7);

    // Gated tick: ticks at k%5==4; PEND at k=2, 4th tick edge is k=19.
    clear_watch();
    raw = 4'h5;
    for (int k = 0; k < 19; k++) begin
      tick = ((k % 5) == 4);
      run_edges(1);
    end
    check("gate_pend", dbg_pend, 4'h2);
    check("gate_q_early", q, 4'h7);
    check("gate_no_fall", acc_fall, 4'h0);
    tick = 1'b1;
    run_edges(1);
    check("gate_fall", fall, 4'h2);
    check("gate_q", q, 4'h5);
    check("gate_changed", changed, 1'b1);
    tick = 1'b0;
    run_edges(1);
    check("gate_fall_off", fall, 4'h0);
    check("gate_idle", dbg_pend, 4'h0);
    tick = 1'b1;

    // Simultaneous changes: clear, then 0 -> A.
    raw = 4'h0;
    run_edges(9);
    check("sim_pre_q", q, 4'h0);
    clear_watch();
    raw = 4'hA;
    run_edges(6);
    check("sim_q_early", q, 4'h0);
    run_edges(1);
    check("sim_rise", rise, 4'hA);
    check("sim_q", q, 4'hA);
    run_edges(5);
    check("sim_changed_once", chg_cnt, 1);
    check("sim_rise_acc", acc_rise, 4'hA);

    // Reset mid-pending on bit 3.
    raw = 4'h2;
    run_edges(9);
    check("mid_pre_q", q, 4'h2);
    clear_watch();
    raw = 4'hA;
    run_edges(3);
    check("mid_pending", dbg_pend, 4'h8);
    nrst = 1'b0;
    #1;
    check("mid_async_q", q, 4'h0);
    check("mid_async_pend", dbg_pend, 4'h0);
    run_edges(2);
    nrst = 1'b1;
    run_edges(6);
    check("mid_no_rise", acc_rise, 4'h0);
    check("mid_q_early", q, 4'h0);
    run_edges(1);
    check("mid_rise", rise, 4'hA);
    check("mid_q", q, 4'hA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
